onchip_ram_pipelined: RTL and testbench
=======================================

ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are multiples of 8, from 8 to 128.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 15, word address width; depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, cycles from read accept to readdatavalid; legal values are 1 and 2.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1; 1 = fill the array after reset, 0 = no fill.
REQ-005 The block SHALL have parameter FILL_VALUE, default 0, DATA_WIDTH-bit word written during fill.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port clken, input, 1, global clock enable; 0 freezes the array, pipeline and FSM.
REQ-009 The block SHALL have port address, input, ADDR_WIDTH, word address.
REQ-010 The block SHALL have port byteenable, input, DATA_WIDTH/8, write byte-lane mask.
REQ-011 The block SHALL have port chipselect, input, 1, slave select.
REQ-012 The block SHALL have port read, input, 1, read request.
REQ-013 The block SHALL have port write, input, 1, write request.
REQ-014 The block SHALL have port writedata, input, DATA_WIDTH, write data.
REQ-015 The block SHALL have port readdata, output, DATA_WIDTH, read data, qualified by readdatavalid.
REQ-016 The block SHALL have port readdatavalid, output, 1, one-cycle pulse per accepted read.
REQ-017 The block SHALL have port waitrequest, output, 1, stall; a request is not accepted while it is 1.
REQ-018 The block SHALL have port init_done, output, 1, set when the array is usable.

Function
REQ-019 The FSM SHALL have two states, CLEAR and READY; reset enters CLEAR when CLEAR_ON_RESET=1 and READY otherwise.
REQ-020 In CLEAR, the block SHALL write FILL_VALUE to every byte lane of one word per clken=1 cycle, using an internal counter that runs from 0 to DEPTH-1.
REQ-021 The FSM SHALL enter READY on the cycle after the fill write to DEPTH-1, so a fill takes DEPTH enabled cycles; the counter must not wrap, and READY is held until the next reset.
REQ-022 waitrequest SHALL be combinational: waitrequest = (state != READY) | ~clken.
REQ-023 init_done SHALL be a registered output equal to 1 only in READY.
REQ-024 A write SHALL be accepted when chipselect & write & ~waitrequest, and SHALL update only the lanes whose byteenable bit is 1; byteenable = 0 leaves the word unchanged.
REQ-025 A read SHALL be accepted when chipselect & read & ~write & ~waitrequest; a read accepted in cycle N SHALL give readdata with readdatavalid=1 in cycle N+READ_LATENCY.
REQ-026 Reads SHALL be fully pipelined: one read can be accepted per cycle, with no bubbles and in order.
REQ-027 If read and write are both asserted, the block SHALL perform the write only, with no readdatavalid for that cycle.
REQ-028 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-029 While clken=0, the block SHALL hold all pipeline stages and the FSM, force readdatavalid=0, and block array writes; pending reads SHALL be delivered in order once clken returns to 1.
REQ-030 readdata SHALL keep its last value when readdatavalid=0; its content then has no meaning.
REQ-031 Address bits SHALL be used as-is; there is no out-of-range case because the array is a full 2^ADDR_WIDTH words.

Reset
REQ-032 When reset is asserted, the block SHALL immediately set readdatavalid=0, readdata=0, init_done=0 and the fill counter to 0, and SHALL clear the pipeline valid bits.
REQ-033 When reset is asserted, the block SHALL set the state to CLEAR when CLEAR_ON_RESET=1 (so waitrequest=1), or to READY otherwise (so init_done=1 from the first clock edge after reset is released).
REQ-034 A reset in the middle of CLEAR SHALL restart the fill from address 0; a reset with reads pending SHALL drop those reads with no readdatavalid.
REQ-035 Reset SHALL NOT clear array contents when CLEAR_ON_RESET=0.

Verification
REQ-036 Fill scenario: ADDR_WIDTH=4, FILL_VALUE=32'hA5A5A5A5, clken=1, reset released -> waitrequest=1 for 16 cycles, then init_done=1; reads of addresses 0..15 all return 32'hA5A5A5A5.
REQ-037 Byte-enable scenario: write 32'h11223344 to address 3 with byteenable=4'hF, then write 32'hFFFFFFFF with byteenable=4'b0101, then read address 3 -> 32'h11FF33FF.
REQ-038 Pipelined-read scenario: READ_LATENCY=2, reads of addresses 0,1,2 on consecutive cycles from cycle N -> readdatavalid=1 in cycles N+2, N+3, N+4, with data in order.
REQ-039 Freeze scenario: with READ_LATENCY=2, one read pending, drive clken=0 for 3 cycles -> waitrequest=1 and readdatavalid=0 during the freeze; the data is delivered 2 enabled cycles after the read was accepted.
REQ-040 Reset-mid-fill scenario: assert reset at fill counter 7 -> waitrequest stays 1, the fill restarts at 0, and init_done rises DEPTH enabled cycles after reset is released.
REQ-041 Collision scenario: chipselect=1 with read=1 and write=1 at address 5 with data 32'hDEADBEEF -> no readdatavalid, and a later read of address 5 returns 32'hDEADBEEF.

Source files
------------

// File: rtl/onchip_ram_pipelined_if.sv
// Avalon-MM style slave bus for the pipelined on-chip RAM.
interface onchip_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect,
    output read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect,
    input  read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_ram_pipelined.sv
// Single-port on-chip RAM with byte lanes, pipelined reads,
// global clock enable and an optional post-reset fill.
module onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic clken,
  onchip_ram_pipelined_if.slave bus,
  output logic init_done
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_pv [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY];

  logic w_wait;
  logic w_wr;
  logic w_rd;

  assign w_wait = (r_state != ST_READY) | ~clken;
  assign w_wr   = bus.chipselect & bus.write & ~w_wait;
  assign w_rd   = bus.chipselect & bus.read & ~bus.write & ~w_wait;

  assign bus.waitrequest   = w_wait;
  assign bus.readdatavalid = r_pv[READ_LATENCY-1] & clken;
  assign bus.readdata      = r_pd[READ_LATENCY-1];
  assign init_done         = r_init_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (r_state == ST_READY)
        r_init_done <= 1'b1;
      // counter parks at the last word instead of wrapping
      if (clken && r_state == ST_CLEAR) begin
        if (r_cnt == '1) begin
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // array has no reset so contents survive when no fill is configured
  always_ff @(posedge clk) begin
    if (clken && !reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_cnt] <= FILL_VALUE;
      end else if (w_wr) begin
        for (int b = 0; b < LANES; b++)
          if (bus.byteenable[b])
            r_mem[bus.address][b*8 +: 8] <= bus.writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else if (clken) begin
      r_pv[0] <= w_rd;
      if (w_rd)
        r_pd[0] <= r_mem[bus.address];
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1])
          r_pd[i] <= r_pd[i-1];
      end
    end
  end
endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Directed bench for onchip_ram_pipelined (16 words, latency 2, fill A5).
module tb_onchip_ram_pipelined;
  logic clk = 1'b0;
  logic reset;
  logic clken;
  logic init_done;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_wait;

  logic [31:0] pexp [3];

  onchip_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  onchip_ram_pipelined #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (4),
    .READ_LATENCY   (2),
    .CLEAR_ON_RESET (1),
    .FILL_VALUE     (32'hA5A5A5A5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    @(negedge clk);
    idle();
  endtask

  task automatic wait_rd(input string tag, input logic [31:0] exp);
    int n = 0;
    while (bus.readdatavalid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.readdatavalid}, 32'd1);
    chk(tag, bus.readdata, exp);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp,
                    input string tag);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = a;
    @(negedge clk);
    idle();
    wait_rd(tag, exp);
  endtask

  task automatic fill_wait(output int n);
    #1;
    n = 0;
    while (bus.waitrequest === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    reset         = 1'b1;
    clken         = 1'b1;
    bus.address   = '0;
    bus.writedata = '0;
    idle();
    pexp[0] = 32'hC0DE0000;
    pexp[1] = 32'hC0DE0001;
    pexp[2] = 32'hC0DE0002;

    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, bus.readdatavalid}, 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    chk("rst_init", {31'd0, init_done}, 32'd0);
    chk("rst_wait", {31'd0, bus.waitrequest}, 32'd1);

    reset = 1'b0;
    fill_wait(n_wait);
    chk("fill_cycles", n_wait, 32'd16);
    chk("fill_init", {31'd0, init_done}, 32'd1);
    for (int a = 0; a < 16; a++)
      rd(a[3:0], 32'hA5A5A5A5, $sformatf("fill_rd%0d", a));

    wr(4'd3, 32'h11223344, 4'hF);
    wr(4'd3, 32'hFFFFFFFF, 4'b0101);
    rd(4'd3, 32'h11FF33FF, "byteen");

    wr(4'd9, 32'h12345678, 4'h0);
    rd(4'd9, 32'hA5A5A5A5, "be_zero");

    for (int i = 0; i < 3; i++)
      wr(i[3:0], pexp[i], 4'hF);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 3) begin
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = c[3:0];
      end else begin
        idle();
      end
      #1;
      chk($sformatf("pipe_v%0d", c), {31'd0, bus.readdatavalid},
          (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 4)
        chk($sformatf("pipe_d%0d", c), bus.readdata, pexp[c-2]);
    end

    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 4'd3;
    #1;
    chk("frz_wait0", {31'd0, bus.waitrequest}, 32'd0);
    @(negedge clk);
    idle();
    clken = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("frz_wait%0d", c), {31'd0, bus.waitrequest}, 32'd1);
      chk($sformatf("frz_v%0d", c), {31'd0, bus.readdatavalid}, 32'd0);
      @(negedge clk);
    end
    clken = 1'b1;
    #1;
    chk("frz_v4", {31'd0, bus.readdatavalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("frz_v5", {31'd0, bus.readdatavalid}, 32'd1);
    chk("frz_d5", bus.readdata, 32'h11FF33FF);
    @(negedge clk);
    #1;
    chk("frz_v6", {31'd0, bus.readdatavalid}, 32'd0);

    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 4'd5;
    bus.writedata  = 32'hDEADBEEF;
    bus.byteenable = 4'hF;
    @(negedge clk);
    idle();
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("coll_v%0d", c), {31'd0, bus.readdatavalid}, 32'd0);
      @(negedge clk);
    end
    rd(4'd5, 32'hDEADBEEF, "coll_rd");

    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 4'd7;
    bus.writedata  = 32'h7E570007;
    bus.byteenable = 4'hF;
    @(negedge clk);
    bus.write      = 1'b0;
    bus.read       = 1'b1;
    @(negedge clk);
    idle();
    wait_rd("raw", 32'h7E570007);

    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 4'd7;
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    chk("rrst_valid", {31'd0, bus.readdatavalid}, 32'd0);
    chk("rrst_rdata", bus.readdata, 32'd0);
    chk("rrst_init", {31'd0, init_done}, 32'd0);
    chk("rrst_wait", {31'd0, bus.waitrequest}, 32'd1);
    @(negedge clk);
    #1;
    chk("rrst_drop", {31'd0, bus.readdatavalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_wait", {31'd0, bus.waitrequest}, 32'd1);
    chk("mid_init", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fill_wait(n_wait);
    chk("mid_cycles", n_wait, 32'd16);
    chk("mid_done", {31'd0, init_done}, 32'd1);
    rd(4'd7, 32'hA5A5A5A5, "refill_rd7");
    rd(4'd3, 32'hA5A5A5A5, "refill_rd3");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
